// File: rtl/ucsbece154b_dmem_wbuf.sv
// Data-memory front end: a FIFO write buffer sits between the core M stage and backing memory.
// Define WB_FORWARD_EN to let loads hit in the buffer; otherwise every load waits for a full drain.
module ucsbece154b_dmem_wbuf #(
    parameter int WB_DEPTH    = 4,
    parameter int MEM_LAT_MAX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM_i,
    input  logic        MemWriteM_i,
    input  logic [31:0] ALUResultM_i,
    input  logic [31:0] WriteDataM_i,
    output logic [31:0] ReadDataM_o,
    output logic        StallM_o,
    output logic        MemReq_o,
    output logic        MemWe_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWData_o,
    input  logic        MemAck_i,
    input  logic [31:0] MemRData_i
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WB_DEPTH);
    localparam int unused_mem_lat = MEM_LAT_MAX;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

    state_t           state, state_next;
    logic [29:0]      wb_addr [WB_DEPTH];
    logic [31:0]      wb_data [WB_DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count, count_next;
    logic [31:0]      rdata;

    logic [29:0] word_addr;
    logic        is_store, is_load, full, push, pop;
    logic        load_miss, read_go, store_stall, load_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic        unused_lsbs;

    assign word_addr   = ALUResultM_i[31:2];
    assign unused_lsbs = ^ALUResultM_i[1:0];
    assign is_store    = MemWriteM_i;
    assign is_load     = MemReadM_i & ~MemWriteM_i;
    assign full        = (count == FULL_CNT);
    assign pop         = (state == WRITE) & MemAck_i;
    assign push        = is_store & (~full | pop);
    assign count_next  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

`ifdef WB_FORWARD_EN
    logic             hit;
    logic [31:0]      fwd_data;
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((k < int'(count)) && (wb_addr[idx] == word_addr)) begin
                hit      = 1'b1;
                fwd_data = wb_data[idx];
            end
        end
    end

    assign load_miss = is_load & ~hit;
    assign read_go   = load_miss;
    assign load_data = (state == RDONE) ? rdata : (hit ? fwd_data : 32'h0);
`else
    // Without forwarding a load may only read memory once nothing older is buffered.
    assign load_miss = is_load;
    assign read_go   = load_miss & (count_next == '0);
    assign load_data = (state == RDONE) ? rdata : 32'h0;
`endif

    assign store_stall = is_store & full & ~pop;
    assign load_stall  = load_miss & (state != RDONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if ((state == READ) && MemAck_i)
                rdata <= MemRData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= word_addr;
            wb_data[tail] <= WriteDataM_i;
        end
    end

    // A pending read takes priority over draining, but never preempts a write already on the bus.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (read_go)
                    state_next = READ;
                else if (count != '0)
                    state_next = WRITE;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {wb_addr[head], 2'b00};
                mem_wdata = wb_data[head];
                if (MemAck_i) begin
                    if (read_go)
                        state_next = READ;
                    else if (count_next != '0)
                        state_next = WRITE;
                    else
                        state_next = IDLE;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = {word_addr, 2'b00};
                if (MemAck_i)
                    state_next = RDONE;
            end
            RDONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign MemReq_o    = mem_req;
    assign MemWe_o     = mem_we;
    assign MemAddr_o   = mem_addr;
    assign MemWData_o  = mem_wdata;
    assign StallM_o    = reset & (store_stall | load_stall);
    assign ReadDataM_o = (reset & is_load) ? load_data : 32'h0;

endmodule
